// File: rtl/id_exe_pipe.sv
// ID->EXE pipeline register: two-entry skid buffer with valid/ready handshake,
// hazard bubble insertion and branch flush. Define ID_EXE_PIPE_PERF_EN for bubble/flush counters.
module id_exe_pipe #(
    parameter int ADDRESS_LEN          = 32,
    parameter int REGISTER_LEN         = 32,
    parameter int REG_ADDRESS_LEN      = 4,
    parameter int EXECUTE_COMMAND_LEN  = 4,
    parameter int SIGNED_IMMEDIATE_LEN = 24,
    parameter int SHIFT_OPERAND_LEN    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            hazard,
    input  logic                            flush,
    input  logic [ADDRESS_LEN-1:0]          in_pc,
    input  logic [EXECUTE_COMMAND_LEN-1:0]  in_execute_command,
    input  logic [REGISTER_LEN-1:0]         in_reg1,
    input  logic [REGISTER_LEN-1:0]         in_reg2,
    input  logic [REG_ADDRESS_LEN-1:0]      in_dest,
    input  logic [SIGNED_IMMEDIATE_LEN-1:0] in_signed_imm,
    input  logic [SHIFT_OPERAND_LEN-1:0]    in_shift_operand,
    input  logic                            in_mem_read,
    input  logic                            in_mem_write,
    input  logic                            in_wb_en,
    input  logic                            in_imm,
    input  logic                            in_branch,
    input  logic                            in_status_we,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDRESS_LEN-1:0]          out_pc,
    output logic [EXECUTE_COMMAND_LEN-1:0]  out_execute_command,
    output logic [REGISTER_LEN-1:0]         out_reg1,
    output logic [REGISTER_LEN-1:0]         out_reg2,
    output logic [REG_ADDRESS_LEN-1:0]      out_dest,
    output logic [SIGNED_IMMEDIATE_LEN-1:0] out_signed_imm,
    output logic [SHIFT_OPERAND_LEN-1:0]    out_shift_operand,
    output logic                            out_mem_read,
    output logic                            out_mem_write,
    output logic                            out_wb_en,
    output logic                            out_imm,
    output logic                            out_branch,
    output logic                            out_status_we
`ifdef ID_EXE_PIPE_PERF_EN
    ,
    output logic [15:0]                     bubble_count,
    output logic [15:0]                     flush_count
`endif
);

    typedef struct packed {
        logic [ADDRESS_LEN-1:0]          pc;
        logic [EXECUTE_COMMAND_LEN-1:0]  execute_command;
        logic [REGISTER_LEN-1:0]         reg1;
        logic [REGISTER_LEN-1:0]         reg2;
        logic [REG_ADDRESS_LEN-1:0]      dest;
        logic [SIGNED_IMMEDIATE_LEN-1:0] signed_imm;
        logic [SHIFT_OPERAND_LEN-1:0]    shift_operand;
        logic                            mem_read;
        logic                            mem_write;
        logic                            wb_en;
        logic                            imm;
        logic                            branch;
        logic                            status_we;
    } payload_t;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t   state_q, state_d;
    payload_t head_q, head_d;
    payload_t tail_q, tail_d;
    payload_t in_entry;
    logic     push, pop;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        in_entry.pc              = in_pc;
        in_entry.execute_command = in_execute_command;
        in_entry.reg1            = in_reg1;
        in_entry.reg2            = in_reg2;
        in_entry.dest            = in_dest;
        in_entry.signed_imm      = in_signed_imm;
        in_entry.shift_operand   = in_shift_operand;
        in_entry.mem_read        = in_mem_read  & ~hazard;
        in_entry.mem_write       = in_mem_write & ~hazard;
        in_entry.wb_en           = in_wb_en     & ~hazard;
        in_entry.imm             = in_imm       & ~hazard;
        in_entry.branch          = in_branch    & ~hazard;
        in_entry.status_we       = in_status_we & ~hazard;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    tail_d  = in_entry;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards held entries and any same-cycle push.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_pc              = head_q.pc;
    assign out_execute_command = head_q.execute_command;
    assign out_reg1            = head_q.reg1;
    assign out_reg2            = head_q.reg2;
    assign out_dest            = head_q.dest;
    assign out_signed_imm      = head_q.signed_imm;
    assign out_shift_operand   = head_q.shift_operand;
    assign out_mem_read        = head_q.mem_read;
    assign out_mem_write       = head_q.mem_write;
    assign out_wb_en           = head_q.wb_en;
    assign out_imm             = head_q.imm;
    assign out_branch          = head_q.branch;
    assign out_status_we       = head_q.status_we;

`ifdef ID_EXE_PIPE_PERF_EN
    logic [15:0] bubble_count_q, bubble_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        if (push && hazard) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
        if (flush && (state_q != EMPTY)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bubble_count = bubble_count_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_exe_pipe.sv
// Bench for id_exe_pipe: directed vector table, then random traffic against a queue model.
module tb_id_exe_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, hazard = 1'b0, flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_reg1 = '0, in_reg2 = '0;
    logic [3:0]  in_execute_command = '0, in_dest = '0;
    logic [23:0] in_signed_imm = '0;
    logic [11:0] in_shift_operand = '0;
    logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_wb_en = 1'b0;
    logic        in_imm = 1'b0, in_branch = 1'b0, in_status_we = 1'b0;
    logic [31:0] out_pc, out_reg1, out_reg2;
    logic [3:0]  out_execute_command, out_dest;
    logic [23:0] out_signed_imm;
    logic [11:0] out_shift_operand;
    logic        out_mem_read, out_mem_write, out_wb_en, out_imm, out_branch, out_status_we;
`ifdef ID_EXE_PIPE_PERF_EN
    logic [15:0] bubble_count, flush_count;
`endif

    id_exe_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .hazard(hazard), .flush(flush),
        .in_pc(in_pc), .in_execute_command(in_execute_command),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_dest(in_dest),
        .in_signed_imm(in_signed_imm), .in_shift_operand(in_shift_operand),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_wb_en(in_wb_en),
        .in_imm(in_imm), .in_branch(in_branch), .in_status_we(in_status_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_execute_command(out_execute_command),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_dest(out_dest),
        .out_signed_imm(out_signed_imm), .out_shift_operand(out_shift_operand),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_wb_en(out_wb_en),
        .out_imm(out_imm), .out_branch(out_branch), .out_status_we(out_status_we)
`ifdef ID_EXE_PIPE_PERF_EN
        , .bubble_count(bubble_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  dest;
        logic [23:0] simm;
        logic [11:0] shop;
        logic [5:0]  ctrl;
    } pl_t;

    typedef struct {
        bit        rst_n, v, hz, fl, ordy;
        logic [31:0] pc;
        logic [5:0]  ctrl;
        bit        e_v, e_r;
        logic [31:0] e_pc;
        logic [5:0]  e_ctrl;
        bit        e_zero;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    pl_t  q[$];
    bit   zero_flag = 1'b1;
    logic [15:0] m_bub = '0, m_fl = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pl_t cur_in();
        pl_t p;
        p = '{in_pc, in_execute_command, in_reg1, in_reg2, in_dest, in_signed_imm, in_shift_operand,
              {in_mem_read, in_mem_write, in_wb_en, in_imm, in_branch, in_status_we}};
        return p;
    endfunction

    function automatic pl_t cur_out();
        pl_t p;
        p = '{out_pc, out_execute_command, out_reg1, out_reg2, out_dest, out_signed_imm, out_shift_operand,
              {out_mem_read, out_mem_write, out_wb_en, out_imm, out_branch, out_status_we}};
        return p;
    endfunction

    task automatic drive(input pl_t p);
        in_pc = p.pc; in_execute_command = p.cmd; in_reg1 = p.r1; in_reg2 = p.r2;
        in_dest = p.dest; in_signed_imm = p.simm; in_shift_operand = p.shop;
        {in_mem_read, in_mem_write, in_wb_en, in_imm, in_branch, in_status_we} = p.ctrl;
    endtask

    // Behavioural model: a FIFO of at most two entries; flush/reset empty it.
    task automatic model_edge();
        int  n;
        pl_t p;
        n = q.size();
        if (!rst) begin
            q.delete();
            zero_flag = 1'b1;
            m_bub = '0;
            m_fl = '0;
        end else if (flush) begin
            if (n != 0) m_fl++;
            q.delete();
        end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) begin
                p = cur_in();
                if (hazard) begin
                    p.ctrl = '0;
                    m_bub++;
                end
                q.push_back(p);
                zero_flag = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        chk("m_out_valid", 256'(out_valid), 256'(q.size() != 0));
        chk("m_in_ready", 256'(in_ready), 256'(q.size() < 2));
        if (q.size() != 0) chk("m_payload", 256'(cur_out()), 256'(q[0]));
        else if (zero_flag) chk("m_zero_payload", 256'(cur_out()), 256'(0));
`ifdef ID_EXE_PIPE_PERF_EN
        chk("m_bubble_count", 256'(bubble_count), 256'(m_bub));
        chk("m_flush_count", 256'(flush_count), 256'(m_fl));
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit rn, bit v, bit hz, bit fl, bit ordy, logic [31:0] pc, logic [5:0] ctrl,
                                bit ev, bit er, logic [31:0] epc, logic [5:0] ectrl, bit ez);
        vec_t t;
        t = '{rn, v, hz, fl, ordy, pc, ctrl, ev, er, epc, ectrl, ez};
        return t;
    endfunction

    vec_t tbl[20];

    initial begin
        pl_t p;
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 1);
        tbl[1]  = mk(1, 1, 0, 0, 1, 32'h04, 6'h3F, 1, 1, 32'h04, 6'h3F, 0);
        tbl[2]  = mk(1, 1, 0, 0, 1, 32'h08, 6'h15, 1, 1, 32'h08, 6'h15, 0);
        tbl[3]  = mk(1, 1, 0, 0, 1, 32'h0C, 6'h15, 1, 1, 32'h0C, 6'h15, 0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 32'h10, 6'h15, 1, 1, 32'h10, 6'h15, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 32'h14, 6'h15, 1, 0, 32'h10, 6'h15, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 32'h18, 6'h15, 1, 0, 32'h10, 6'h15, 0);
        tbl[8]  = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 1, 1, 32'h14, 6'h15, 0);
        tbl[9]  = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 0);
        tbl[10] = mk(1, 1, 1, 0, 0, 32'h20, 6'h18, 1, 1, 32'h20, 6'h00, 0);
        tbl[11] = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 0);
        tbl[12] = mk(1, 1, 0, 0, 0, 32'h24, 6'h15, 1, 1, 32'h24, 6'h15, 0);
        tbl[13] = mk(1, 1, 0, 0, 0, 32'h28, 6'h15, 1, 0, 32'h24, 6'h15, 0);
        tbl[14] = mk(1, 1, 0, 1, 1, 32'h30, 6'h15, 0, 1, 32'h00, 6'h00, 0);
        tbl[15] = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 0);
        tbl[16] = mk(1, 1, 0, 0, 0, 32'h40, 6'h15, 1, 1, 32'h40, 6'h15, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 32'h44, 6'h15, 0, 1, 32'h00, 6'h00, 1);
        tbl[18] = mk(1, 1, 0, 0, 1, 32'h48, 6'h2A, 1, 1, 32'h48, 6'h2A, 0);
        tbl[19] = mk(1, 0, 0, 0, 1, 32'h00, 6'h00, 0, 1, 32'h00, 6'h00, 0);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst_n; in_valid = tbl[i].v; hazard = tbl[i].hz;
            flush = tbl[i].fl; out_ready = tbl[i].ordy;
            p = '{tbl[i].pc, tbl[i].pc[3:0], tbl[i].pc * 3, ~tbl[i].pc, tbl[i].pc[5:2],
                  tbl[i].pc[23:0] ^ 24'hA5A5A5, tbl[i].pc[11:0] + 12'h111, tbl[i].ctrl};
            drive(p);
            cycle();
            chk($sformatf("v%0d_out_valid", i), 256'(out_valid), 256'(tbl[i].e_v));
            chk($sformatf("v%0d_in_ready", i), 256'(in_ready), 256'(tbl[i].e_r));
            if (tbl[i].e_v) begin
                chk($sformatf("v%0d_out_pc", i), 256'(out_pc), 256'(tbl[i].e_pc));
                chk($sformatf("v%0d_ctrl", i),
                    256'({out_mem_read, out_mem_write, out_wb_en, out_imm, out_branch, out_status_we}),
                    256'(tbl[i].e_ctrl));
            end
            if (tbl[i].e_zero) chk($sformatf("v%0d_zero", i), 256'(cur_out()), 256'(0));
`ifdef ID_EXE_PIPE_PERF_EN
            if (i == 10) chk("bubble_count_after_hazard", 256'(bubble_count), 256'(1));
            if (i == 14) chk("flush_count_after_flush", 256'(flush_count), 256'(1));
`endif
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            hazard    = ($urandom_range(0, 9) < 2);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            p = pl_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            drive(p);
            cycle();
            model_check();
        end

        // Payload hold under backpressure.
        rst = 1'b1; flush = 1'b0; hazard = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        drive(pl_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
        cycle();
        drive(pl_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
        cycle();
        p = cur_out();
        for (int i = 0; i < 4; i++) begin
            drive(pl_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
            cycle();
            chk("hold_payload", 256'(cur_out()), 256'(p));
            model_check();
        end

`ifdef ID_EXE_PIPE_PERF_EN
        // Bubble counter wrap.
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        rst = 1'b1; in_valid = 1'b1; hazard = 1'b1; out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            cycle();
            if (i == 65534) chk("bubble_count_ffff", 256'(bubble_count), 256'(16'hFFFF));
        end
        chk("bubble_count_wrap", 256'(bubble_count), 256'(0));
        model_check();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
